// File: rtl/rst_req_gen.sv
// Reset-request generator: merges software, watchdog and debounced button requests
// into one registered, fixed-width rst_req pulse followed by a cooldown window.
module rst_req_gen #(
    parameter int WDT_TIMEOUT = 1000,
    parameter int HOLD_CYC    = 16,
    parameter int COOL_CYC    = 8,
    parameter int DEB_CYC     = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       asrst,
    input  logic       sw_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    input  logic       btn_n,
    output logic       rst_req,
    output logic [2:0] rst_cause,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO      = '0;
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_FULL  = CNT_W'(DEB_CYC);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] fsm_cnt, fsm_cnt_nxt;
    logic [CNT_W-1:0] wdt_cnt;
    logic [CNT_W-1:0] deb_cnt;
    logic [2:0]       cause_nxt;
    logic             req_nxt;
    logic             busy_nxt;
    logic             btn_s1, btn_s2;
    logic             btn_evt, wdt_evt;
    logic [2:0]       req_vec;

    // Button synchronizer; idles high so reset never looks like a press.
    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce counter saturates at DEB_CYC so a long press yields a single event.
    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            deb_cnt <= ZERO;
        end else if (btn_s2) begin
            deb_cnt <= ZERO;
        end else if (deb_cnt != DEB_FULL) begin
            deb_cnt <= deb_cnt + ONE;
        end
    end

    assign btn_evt = !btn_s2 && (deb_cnt == DEB_LAST);
    assign wdt_evt = (state == IDLE) && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);
    assign req_vec = {btn_evt, wdt_evt, sw_req};

    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            wdt_cnt <= ZERO;
        end else if ((state != IDLE) || !wdt_en || wdt_kick || (wdt_cnt == WDT_LAST)) begin
            wdt_cnt <= ZERO;
        end else begin
            wdt_cnt <= wdt_cnt + ONE;
        end
    end

    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            state     <= IDLE;
            fsm_cnt   <= ZERO;
            rst_req   <= 1'b0;
            rst_cause <= 3'b000;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            fsm_cnt   <= fsm_cnt_nxt;
            rst_req   <= req_nxt;
            rst_cause <= cause_nxt;
            busy      <= busy_nxt;
        end
    end

    // Outputs are computed for the next state so rst_req and busy come straight from flops.
    always_comb begin
        state_nxt   = state;
        fsm_cnt_nxt = fsm_cnt;
        cause_nxt   = rst_cause;
        req_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    state_nxt   = ASSERT;
                    fsm_cnt_nxt = ZERO;
                    cause_nxt   = req_vec;
                    req_nxt     = 1'b1;
                end
            end
            ASSERT: begin
                if (fsm_cnt == HOLD_LAST) begin
                    state_nxt   = COOLDOWN;
                    fsm_cnt_nxt = ZERO;
                end else begin
                    fsm_cnt_nxt = fsm_cnt + ONE;
                    req_nxt     = 1'b1;
                end
            end
            COOLDOWN: begin
                if (fsm_cnt == COOL_LAST) begin
                    state_nxt   = IDLE;
                    fsm_cnt_nxt = ZERO;
                end else begin
                    fsm_cnt_nxt = fsm_cnt + ONE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                fsm_cnt_nxt = ZERO;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule
